// File: rtl/rv32_decode_queue_stage_pkg.sv
// Shared types for the queued decode stage: control bundle,
// decode/exec buffer, queue entry and the bubble helper.
package rv32_decode_queue_stage_pkg;

  localparam int CORE_RF_NUM_READ   = 3;
  localparam int DECQ_DEPTH_DEFAULT = 4;
  localparam logic [31:0] RV_NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {
    BYP_NONE, BYP_EX, BYP_MEM, BYP_WB
  } bypass_t;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_CSR
  } wb_src_t;

  typedef struct packed {
    logic    is_bubble;
    logic    reg_write;
    wb_src_t wb_result_src;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_src;
    logic [2:0] alu_op;
    bypass_t [CORE_RF_NUM_READ-1:0] bypass_rs;
  } rv_control_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    rv_control_t control;
    logic [CORE_RF_NUM_READ-1:0][31:0] reg_data;
  } decode_exec_buffer_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bubble;
  } decq_entry_t;

  function automatic rv_control_t create_bubble_ctrl();
    rv_control_t c;
    c = '0;
    c.is_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/rv32_decode_queue_stage_if.sv
// Fetch -> decode-queue handshake: valid/ready plus {pc, instr, bubble}.
// master = fetch side, slave = decode queue side.
interface rv32_decode_queue_stage_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        bubble;

  modport master (
    output valid, pc, instr, bubble,
    input  ready
  );

  modport slave (
    input  valid, pc, instr, bubble,
    output ready
  );
endinterface

// File: rtl/rv32_decoder.sv
// RV32I opcode decoder: instruction word -> control bundle and rs usage.
// Ports: i_instr in, o_control / o_use_rs out (bypass_rs left zero).
module rv32_decoder
  import rv32_decode_queue_stage_pkg::*;
(
  input  logic [31:0]                 i_instr,
  output rv_control_t                 o_control,
  output logic [CORE_RF_NUM_READ-1:0] o_use_rs
);
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_unused;

  assign w_op     = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_unused = ^{i_instr[31:15], i_instr[11:7]};

  always_comb begin
    o_control        = '0;
    o_use_rs         = '0;
    o_control.alu_op = w_f3;
    unique case (1'b1)
      w_op == 7'h13: begin
        o_control.reg_write = 1'b1;
        o_control.alu_src   = 1'b1;
        o_use_rs[0]         = 1'b1;
      end
      w_op == 7'h33: begin
        o_control.reg_write = 1'b1;
        o_use_rs[1:0]       = 2'b11;
      end
      w_op == 7'h03: begin
        o_control.reg_write     = 1'b1;
        o_control.mem_read      = 1'b1;
        o_control.alu_src       = 1'b1;
        o_control.wb_result_src = WB_MEM;
        o_use_rs[0]             = 1'b1;
      end
      w_op == 7'h23: begin
        o_control.mem_write = 1'b1;
        o_control.alu_src   = 1'b1;
        o_use_rs[1:0]       = 2'b11;
      end
      w_op == 7'h63: begin
        o_control.branch = 1'b1;
        o_use_rs[1:0]    = 2'b11;
      end
      w_op == 7'h6f: begin
        o_control.jump          = 1'b1;
        o_control.reg_write     = 1'b1;
        o_control.wb_result_src = WB_PC4;
      end
      w_op == 7'h67: begin
        o_control.jump          = 1'b1;
        o_control.reg_write     = 1'b1;
        o_control.wb_result_src = WB_PC4;
        o_use_rs[0]             = 1'b1;
      end
      w_op == 7'h37, w_op == 7'h17: begin
        o_control.reg_write = 1'b1;
        o_control.alu_src   = 1'b1;
      end
      w_op == 7'h73 && w_f3 != 3'd0: begin
        o_control.reg_write     = 1'b1;
        o_control.wb_result_src = WB_CSR;
        o_use_rs[0]             = ~w_f3[2];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/rv32_instr_queue.sv
// Generic circular FIFO with flush, occupancy count and push/pop.
// Ports: clk, reset, i_flush, i_push, i_pop, i_data, o_data(head), o_count, o_full, o_empty.
module rv32_instr_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/rv32_decode_queue_stage.sv
// Decode stage with a DEPTH-entry instruction queue in front of it.
// Ports: clk, reset, fetch (slave handshake), i_flush/i_flush_pc,
// i_stop, i_hazard_stall, i_bypass_rs, i_reg_data, i_csr_data in;
// o_head_instr/_use_rs/_control, o_decode_exec_buff, o_queue_count out.
// RV32_DECQ_BYPASS_EN: decode an empty-queue fetch entry directly.
module rv32_decode_queue_stage
  import rv32_decode_queue_stage_pkg::*;
#(
  parameter int DEPTH    = DECQ_DEPTH_DEFAULT,
  parameter int NUM_READ = CORE_RF_NUM_READ,
  parameter int CSR_SLOT = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  rv32_decode_queue_stage_if.slave     fetch,
  input  logic                         i_flush,
  input  logic [31:0]                  i_flush_pc,
  input  logic                         i_stop,
  input  logic                         i_hazard_stall,
  input  bypass_t [NUM_READ-1:0]       i_bypass_rs,
  output logic [31:0]                  o_head_instr,
  output logic [NUM_READ-1:0]          o_head_use_rs,
  output rv_control_t                  o_head_control,
  input  logic [NUM_READ-1:0][31:0]    i_reg_data,
  input  logic [31:0]                  i_csr_data,
  output decode_exec_buffer_t          o_decode_exec_buff,
  output logic [$clog2(DEPTH):0]       o_queue_count
);
  decq_entry_t         w_fe;
  decq_entry_t         w_head;
  decq_entry_t         w_src;
  logic                w_full;
  logic                w_empty;
  logic                w_byp;
  logic                w_have;
  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  rv_control_t         w_dec_ctrl;
  logic [NUM_READ-1:0][31:0] w_rd;
  decode_exec_buffer_t w_next;
  decode_exec_buffer_t r_buff;

  assign w_fe.pc     = fetch.pc;
  assign w_fe.instr  = fetch.instr;
  assign w_fe.bubble = fetch.bubble;

  rv32_instr_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(decq_entry_t))
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_flush (i_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_fe),
    .o_data  (w_head),
    .o_count (o_queue_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Ready is a function of occupancy only.
  assign fetch.ready = ~w_full;

`ifdef RV32_DECQ_BYPASS_EN
  assign w_byp = w_empty & fetch.valid & ~i_flush;
`else
  assign w_byp = 1'b0;
`endif

  assign w_src   = w_byp ? w_fe : w_head;
  assign w_have  = ~w_empty | w_byp;
  assign w_issue = w_have & ~i_hazard_stall
                 & ~i_stop & ~i_flush;
  assign w_pop   = ~w_empty & w_issue;
  // A bypassed entry that issues never enters the queue.
  assign w_push  = fetch.valid & fetch.ready
                 & ~i_flush & ~(w_byp & w_issue);

  assign o_head_instr = (~w_have | w_src.bubble)
                      ? RV_NOP : w_src.instr;

  rv32_decoder u_dec (
    .i_instr   (o_head_instr),
    .o_control (w_dec_ctrl),
    .o_use_rs  (o_head_use_rs)
  );

  always_comb begin
    o_head_control           = w_dec_ctrl;
    o_head_control.bypass_rs = i_bypass_rs;
  end

  always_comb begin
    w_rd = i_reg_data;
    if (o_head_control.wb_result_src == WB_CSR)
      w_rd[CSR_SLOT] = i_csr_data;
  end

  always_comb begin
    w_next         = '0;
    w_next.instr   = RV_NOP;
    w_next.control = create_bubble_ctrl();
    w_next.pc      = w_have ? w_src.pc : r_buff.pc;
    unique case (1'b1)
      i_flush: w_next.pc = i_flush_pc;
      w_issue: begin
        w_next.pc       = w_src.pc;
        w_next.instr    = o_head_instr;
        w_next.control  = o_head_control;
        w_next.reg_data = w_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buff.pc       <= '0;
      r_buff.instr    <= RV_NOP;
      r_buff.control  <= create_bubble_ctrl();
      r_buff.reg_data <= '0;
    end else if (!i_stop) begin
      r_buff <= w_next;
    end
  end

  assign o_decode_exec_buff = r_buff;
endmodule

// File: tb/tb_rv32_decode_queue_stage.sv
// Bench for rv32_decode_queue_stage: directed scenarios plus
// random traffic checked against a queue-based reference model.
module tb_rv32_decode_queue_stage;
  import rv32_decode_queue_stage_pkg::*;

  localparam int DEPTH = 4;
  localparam int NR    = CORE_RF_NUM_READ;
`ifdef RV32_DECQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32_decode_queue_stage_if fetch_if();

  logic                flush, stop, stall;
  logic [31:0]         flush_pc, csr;
  bypass_t [NR-1:0]    byp;
  logic [NR-1:0][31:0] rdata;
  logic [31:0]         head_instr;
  logic [NR-1:0]       head_use;
  rv_control_t         head_ctrl;
  decode_exec_buffer_t buff;
  logic [$clog2(DEPTH):0] qcnt;

  rv32_decode_queue_stage #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .fetch              (fetch_if),
    .i_flush            (flush),
    .i_flush_pc         (flush_pc),
    .i_stop             (stop),
    .i_hazard_stall     (stall),
    .i_bypass_rs        (byp),
    .o_head_instr       (head_instr),
    .o_head_use_rs      (head_use),
    .o_head_control     (head_ctrl),
    .i_reg_data         (rdata),
    .i_csr_data         (csr),
    .o_decode_exec_buff (buff),
    .o_queue_count      (qcnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  decq_entry_t mq[$];
  logic [31:0] e_pc, e_instr, e_rd2;
  logic        e_bub;
  bit          rnd = 1;

  logic [31:0] tab [8] = '{
    32'h0050_0093, 32'h0020_81b3, 32'h0000_a103,
    32'h0020_a023, 32'h0020_8463, 32'h3000_22f3,
    32'h3410_1073, 32'h0080_00ef
  };

  function automatic bit is_csr(logic [31:0] ins);
    return ins[6:0] == 7'h73 && ins[14:12] != 3'd0;
  endfunction

  task automatic idle();
    fetch_if.valid  = 0;
    fetch_if.pc     = 0;
    fetch_if.instr  = RV_NOP;
    fetch_if.bubble = 0;
    flush = 0; stop = 0; stall = 0;
    flush_pc = 0; csr = 0;
    for (int i = 0; i < NR; i++) begin
      byp[i] = BYP_NONE;
      rdata[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    mq.delete();
    e_pc = 0; e_instr = RV_NOP; e_bub = 1; e_rd2 = 0;
    chk("rst_cnt", qcnt, 0);
    chk("rst_rdy", fetch_if.ready, 1);
    chk("rst_pc", buff.pc, 0);
    chk("rst_ins", buff.instr, RV_NOP);
    chk("rst_bub", buff.control.is_bubble, 1);
  endtask

  // Called at posedge+1 with inputs set; returns at next posedge+1.
  task automatic step();
    int n;
    bit byp_en, have, iss;
    decq_entry_t src, fe;
    logic [31:0] hi;
    if (rnd) begin
      csr = $urandom;
      for (int i = 0; i < NR; i++) begin
        rdata[i] = $urandom;
        byp[i] = bypass_t'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    fe.pc = fetch_if.pc;
    fe.instr = fetch_if.instr;
    fe.bubble = fetch_if.bubble;
    n = mq.size();
    byp_en = 0;
`ifdef RV32_DECQ_BYPASS_EN
    byp_en = (n == 0) && fetch_if.valid && !flush;
`endif
    have = (n > 0) || byp_en;
    src = (n > 0) ? mq[0] : fe;
    hi = (!have || src.bubble) ? RV_NOP : src.instr;
    chk("ready", fetch_if.ready, n < DEPTH);
    chk("count", qcnt, n);
    chk("head", head_instr, hi);
    chk("hbyp", head_ctrl.bypass_rs, byp);
    iss = have && !stall && !stop && !flush;
    if (!stop) begin
      if (flush) begin
        e_pc = flush_pc; e_instr = RV_NOP; e_bub = 1;
      end else if (iss) begin
        e_pc = src.pc; e_instr = hi; e_bub = 0;
        e_rd2 = is_csr(hi) ? csr : rdata[2];
      end else begin
        if (have) e_pc = src.pc;
        e_instr = RV_NOP; e_bub = 1;
      end
    end
    if (flush) mq.delete();
    else begin
      if (iss && n > 0) void'(mq.pop_front());
      if (fetch_if.valid && n < DEPTH && !(byp_en && iss))
        mq.push_back(fe);
    end
    @(posedge clk); #1;
    chk("pc", buff.pc, e_pc);
    chk("instr", buff.instr, e_instr);
    chk("bub", buff.control.is_bubble, e_bub);
    if (!e_bub) chk("slot2", buff.reg_data[2], e_rd2);
    chk("cnt_post", qcnt, mq.size());
  endtask

  task automatic offer(logic [31:0] pc, logic [31:0] ins);
    fetch_if.valid = 1;
    fetch_if.pc = pc;
    fetch_if.instr = ins;
    fetch_if.bubble = 0;
  endtask

  initial begin
    int lat, k;
    bit acc;
    reset = 1;
    idle();
    do_reset();

    // ADDI latency
    offer(32'h100, 32'h0050_0093);
    step();
    fetch_if.valid = 0;
    lat = 1;
    while (buff.pc !== 32'h100 && lat < 6) begin
      step();
      lat++;
    end
    chk("lat", lat, LAT);
    chk("addi_bub", buff.control.is_bubble, 0);
    step();
    chk("addi_cnt", qcnt, 0);

    // Stall fill, then in-order drain
    stall = 1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (k < 4) offer(32'h200 + 4 * k, tab[k]);
      else fetch_if.valid = 0;
      acc = fetch_if.ready && fetch_if.valid;
      step();
      if (acc) k++;
    end
    chk("full_rdy", fetch_if.ready, 0);
    chk("full_cnt", qcnt, 4);
    stall = 0;
    fetch_if.valid = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("order", buff.pc, 32'h200 + 4 * j);
    end

    // Flush a full queue
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      offer(32'h280 + 4 * i, tab[i]);
      step();
    end
    offer(32'h300, tab[0]);
    flush = 1;
    flush_pc = 32'h400;
    step();
    flush = 0;
    fetch_if.valid = 0;
    chk("fl_cnt", qcnt, 0);
    chk("fl_pc", buff.pc, 32'h400);
    chk("fl_bub", buff.control.is_bubble, 1);
    stall = 0;
    step();

    // Stop with two entries queued
    stall = 1;
    offer(32'h700, tab[1]);
    step();
    offer(32'h704, tab[2]);
    step();
    fetch_if.valid = 0;
    stall = 0;
    stop = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stop_cnt", qcnt, 2);
    stop = 0;
    step();
    chk("stop_a", buff.pc, 32'h700);
    step();
    chk("stop_b", buff.pc, 32'h704);

    // CSR slot overwrite
    rnd = 0;
    csr = 32'h1800;
    offer(32'h600, 32'h3000_22f3);
    step();
    fetch_if.valid = 0;
    lat = 1;
    while (buff.pc !== 32'h600 && lat < 6) begin
      step();
      lat++;
    end
    chk("csr", buff.reg_data[2], 32'h1800);
    rnd = 1;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      fetch_if.valid  = ($urandom % 4) != 0;
      fetch_if.pc     = {$urandom, 2'b00};
      fetch_if.instr  = tab[$urandom % 8];
      fetch_if.bubble = ($urandom % 8) == 0;
      stall    = ($urandom % 4) == 0;
      stop     = ($urandom % 8) == 0;
      flush    = ($urandom % 16) == 0;
      flush_pc = {$urandom, 2'b00};
      if (c == 200) begin
        fetch_if.valid = 1;
        do_reset();
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32_decode_queue_stage.md
Name: rv32_decode_queue_stage

Overview:
- Parametrised successor to the core's decode stage (pipeline stage 2).
- Adds a DEPTH-entry instruction queue between fetch and decode, so fetch keeps filling while decode stalls on hazards or `stop`.
- Decodes the queue head, reads the register and CSR files, and registers the result into the decode/exec buffer.
- A flush empties the queue and injects a bubble carrying the redirect PC.

Parameters:
- DEPTH, 4: queue entries. Power of two, ≥2.
- NUM_READ, CORE_RF_NUM_READ: register-file read ports carried in the buffer.
- CSR_SLOT, 2: reg_data index overwritten with csr_data when wb_result_src==WB_CSR.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch offers an entry.
- fetch_ready  out  1  queue accepts the entry (count != DEPTH).
- fetch_pc  in  32  PC of the entry.
- fetch_instr  in  32  instruction word.
- fetch_bubble  in  1  entry is a fetch bubble; it is decoded as RV_NOP.
- flush  in  1  redirect: drop the queue, emit a bubble.
- flush_pc  in  32  PC given to the flush bubble.
- stop  in  1  freeze the output register; do not pop.
- hazard_stall  in  1  from the external hazard unit; head cannot issue.
- bypass_rs  in  NUM_READ x bypass_t  from the hazard unit.
- head_instr  out  32  decoded head instruction (RV_NOP if empty or bubble), fed to the hazard unit.
- head_use_rs  out  NUM_READ  decoder use_rs for the head.
- head_control  out  rv_control_t  decoder control for the head.
- reg_data  in  NUM_READ x 32  register-file read data for the head.
- csr_data  in  32  CSR read data for the head.
- decode_exec_buff  out  decode_exec_buffer_t  registered stage output.
- queue_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: pointers=0, count=0, fetch_ready=1.
- Reset: decode_exec_buff.instr=RV_NOP, .control=create_bubble_ctrl(), .pc=0.
- Queue is a circular buffer of {pc, instr, bubble} with rd_ptr/wr_ptr wrapping modulo DEPTH.
- push = fetch_valid & fetch_ready & !flush.
- pop = (count!=0) & !hazard_stall & !stop & !flush.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- fetch_ready depends only on count, never on pop. There is no combinational path ready<-stall.
- A full queue accepts no entry even if a pop occurs that cycle.
- Head decode is combinational:
  - instr = RV_NOP if empty or bubble.
  - Control comes from the rv32_decoder instance.
  - bypass_rs is overlaid into control.bypass_rs.
  - reg_data is forwarded; reg_data[CSR_SLOT] = csr_data when wb_result_src==WB_CSR.
- Output register, when !stop:
  - flush: bubble, pc=flush_pc.
  - Otherwise pop: decoded head.
  - Otherwise (empty or stalled): bubble, pc = head pc or the last output pc if empty.
- Output register, when stop: holds its value.
- Flush clears the queue (count=0, rd_ptr=wr_ptr=0) even when stop=1. The output register still obeys stop.
- Latency: an entry pushed in cycle t reaches decode_exec_buff at the end of cycle t+1 at the earliest.
- Reset asserted mid-operation discards all entries within one cycle, with no partial pops.

Optional Feature:
- RV32_DECQ_BYPASS_EN defined:
  - When count==0, fetch_valid=1 and !flush, the fetch entry is decoded directly. Latency is 1 cycle.
  - If it also issues (no stall/stop), it is not written into the queue.
  - If it does not issue, it is pushed normally.
- Undefined: every entry passes through the queue; minimum latency is 2 cycles.

Decomposition:
- rv32_types gains:
  - decq_entry_t {pc, instr, bubble}.
  - DECQ_DEPTH_DEFAULT.
- Reuse decode_exec_buffer_t, rv_control_t, bypass_t, RV_NOP and create_bubble_ctrl() from the package.
- One natural sub-module: rv32_instr_queue (generic circular FIFO with flush, count, push/pop).
- rv32_decoder is instantiated unchanged.

Test Plan:
- Reset then push pc=0x100 ADDI x1,x0,5, no stall -> cycle after next: buff.pc=0x100, instr=ADDI, not a bubble; queue_count returns to 0.
- hazard_stall=1 for 6 cycles while fetch pushes pcs 0x200..0x20C (DEPTH=4) -> fetch_ready=0 after 4 pushes; output bubbles; on release pcs issue in order 0x200,0x204,0x208,0x20C.
- Queue full, flush=1 with flush_pc=0x400 -> next cycle count=0; buff is a bubble with pc=0x400; the push that cycle is dropped.
- stop=1 for 3 cycles with 2 entries queued -> buff unchanged, count stays 2; after stop falls, entries issue on consecutive cycles.
- CSRRS x5,mstatus with csr_data=0x1800 -> buff.reg_data[2]=0x1800.
- With RV32_DECQ_BYPASS_EN, an empty queue and pc=0x500 -> buff.pc=0x500 one cycle later, count stays 0.
- Without RV32_DECQ_BYPASS_EN, same stimulus -> buff.pc=0x500 two cycles later.
